// File: rtl/lc3b_mem_pkg.sv
// Shared types and encodings for the LC-3b memory access controller.
package lc3b_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        COMPLETE,
        FAULT,
        ABORT
    } state_e;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_LO   = 2'b01;
    localparam logic [1:0] WE_HI   = 2'b10;
    localparam logic [1:0] WE_WORD = 2'b11;

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering for LC-3b accesses: sign-extending load select and
// store byte replication with per-lane write enables.
module mem_byte_lane
    import lc3b_mem_pkg::*;
(
    input  logic        active,
    input  logic        write,
    input  logic        size,
    input  logic        byte_sel,
    input  logic [15:0] wdata,
    input  logic [15:0] rdata,
    output logic [15:0] load_val,
    output logic [15:0] store_val,
    output logic [1:0]  we
);

    always_comb begin
        load_val  = rdata;
        store_val = wdata;
        we        = WE_NONE;

        if (size == SIZE_BYTE) begin
            load_val  = byte_sel ? {{8{rdata[15]}}, rdata[15:8]}
                                 : {{8{rdata[7]}},  rdata[7:0]};
            store_val = {wdata[7:0], wdata[7:0]};
        end

        // Write enables exist only while the memory request is live.
        if (active && write) begin
            if (size == SIZE_WORD) begin
                we = WE_WORD;
            end else begin
                we = byte_sel ? WE_HI : WE_LO;
            end
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3b memory access controller: latches MAR, runs one LDW/LDB/STW/STB
// transaction against a ready-handshake memory, reports alignment/timeout faults.
module mem_access_ctrl
    import lc3b_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_WIDTH      = 8
)
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [15:0] ADDR,
    input  logic        WRITE,
    input  logic        SIZE,
    input  logic [15:0] WDATA,
    output logic        MEM_EN,
    output logic [1:0]  MEM_WE,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_WDATA,
    input  logic        MEM_R,
    input  logic [15:0] MEM_RDATA,
    output logic [15:0] MDR,
    output logic [15:0] MAR,
    output logic        BUSY,
    output logic        DONE,
    output logic        ALIGN_ERR,
    output logic        TIMEOUT_ERR
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [15:0]           mar_q, mar_d;
    logic [15:0]           mdr_q, mdr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic                  size_q, size_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  access_active;
    logic [15:0]           load_val;

    assign access_active = (state_q == ACCESS);

    mem_byte_lane u_lane (
        .active    (access_active),
        .write     (write_q),
        .size      (size_q),
        .byte_sel  (mar_q[0]),
        .wdata     (wdata_q),
        .rdata     (MEM_RDATA),
        .load_val  (load_val),
        .store_val (MEM_WDATA),
        .we        (MEM_WE)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            size_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        size_d  = size_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    mar_d   = ADDR;
                    write_d = WRITE;
                    size_d  = SIZE;
                    wdata_d = WDATA;
                    cnt_d   = '0;
                    state_d = (SIZE == SIZE_WORD && ADDR[0]) ? FAULT : ACCESS;
                end
            end
            ACCESS: begin
                // A ready on the last permitted cycle wins over the timeout.
                if (MEM_R) begin
                    if (!write_q) begin
                        mdr_d = load_val;
                    end
                    state_d = COMPLETE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ABORT;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            COMPLETE: state_d = IDLE;
            FAULT:    state_d = IDLE;
            ABORT:    state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign MEM_EN      = access_active;
    assign MEM_ADDR    = {mar_q[15:1], 1'b0};
    assign MDR         = mdr_q;
    assign MAR         = mar_q;
    assign BUSY        = (state_q != IDLE);
    assign DONE        = (state_q == COMPLETE);
    assign ALIGN_ERR   = (state_q == FAULT);
    assign TIMEOUT_ERR = (state_q == ABORT);

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory access controller downstream of the address adder; captures the computed effective address into MAR and runs one LC-3b memory transaction.
- Transaction types are LDW, LDB, STW and STB, over a variable-latency memory that uses a ready (R) handshake.
- Returns the loaded value as MDR contents to the datapath, or reports an alignment or timeout fault.

Parameters:
- TIMEOUT_CYCLES, 15: maximum ACCESS cycles without MEM_R before the transaction aborts (range 1..255).
- CNT_WIDTH, 8: width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  request a transaction; sampled only in IDLE.
- ADDR  input  16  effective address from the address adder.
- WRITE  input  1  1 = store, 0 = load.
- SIZE  input  1  1 = word, 0 = byte.
- WDATA  input  16  store data (SR value); for byte stores only [7:0] is used.
- MEM_EN  output  1  memory request, held through ACCESS.
- MEM_WE  output  2  byte-lane write enables: [1] = high byte, [0] = low byte.
- MEM_ADDR  output  16  word-aligned address {MAR[15:1],1'b0}.
- MEM_WDATA  output  16  store data driven to memory.
- MEM_R  input  1  memory ready; the transaction completes on the edge where it is sampled high.
- MEM_RDATA  input  16  read data; valid when MEM_R=1.
- MDR  output  16  loaded value; holds until the next load completes.
- MAR  output  16  latched address.
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  one-cycle pulse on successful completion.
- ALIGN_ERR  output  1  one-cycle pulse when a word access is unaligned.
- TIMEOUT_ERR  output  1  one-cycle pulse when the transaction is aborted.

Behaviour:
- Reset (asynchronous): state=IDLE; MAR, MDR, wait counter, and all latched request fields cleared to 0; every output 0. A reset mid-transaction deasserts MEM_EN and MEM_WE immediately, with no DONE or error pulse.
- IDLE:
  - START=1 latches MAR<=ADDR, plus WRITE, SIZE and WDATA; counter<=0.
  - If SIZE=1 and ADDR[0]=1, go to FAULT. Otherwise go to ACCESS.
  - START=0 stays in IDLE. START asserted in any other state is ignored, not queued.
- ACCESS:
  - MEM_EN=1.
  - MEM_WE is 0 for loads. For stores: word = 2'b11; byte = MAR[0] ? 2'b10 : 2'b01.
  - Byte stores drive MEM_WDATA={WDATA[7:0],WDATA[7:0]}; word stores drive WDATA unchanged.
  - MEM_R=1 ends the access; load data is captured into MDR on that edge; next state COMPLETE.
  - Load capture: a word load takes MEM_RDATA unchanged. A byte load takes the byte selected by MAR[0] (0 = [7:0], 1 = [15:8]) and sign-extends it to 16 bits.
  - MEM_R=0: counter increments. If counter reaches TIMEOUT_CYCLES-1 with MEM_R still 0, go to ABORT, MDR unchanged.
  - MEM_R=1 on the final permitted cycle still counts as success.
- COMPLETE: DONE=1 for one cycle, then IDLE.
- FAULT: ALIGN_ERR=1 for one cycle, no memory activity, then IDLE.
- ABORT: TIMEOUT_ERR=1 for one cycle, MEM_EN=0, then IDLE.
- Latency: START accepted at edge t puts the block in ACCESS during cycle t+1. With MEM_R=1 in the first ACCESS cycle, DONE is high in cycle t+2. Back-to-back START is accepted in the cycle after DONE (IDLE).
- MAR wraps naturally: no address arithmetic is performed here, and 16'hFFFF with a byte access is legal.
- Outputs are registered or decoded from state only; MEM_RDATA has no combinational path to MDR.

Decomposition:
- Package lc3b_mem_pkg:
  - state encoding: IDLE, ACCESS, COMPLETE, FAULT, ABORT;
  - SIZE_BYTE=0, SIZE_WORD=1;
  - WE_NONE=2'b00, WE_LO=2'b01, WE_HI=2'b10, WE_WORD=2'b11.
- Sub-module mem_byte_lane (combinational):
  - read path: lane select plus sign extension;
  - write path: byte replication plus WE generation.
  - The FSM, MAR, MDR and counter stay in mem_access_ctrl.

Test Plan:
- LDW: ADDR=16'h3000, memory returns 16'hBEEF with MEM_R on the 3rd ACCESS cycle -> MEM_ADDR=16'h3000, MEM_WE=0, MDR=16'hBEEF, DONE pulses exactly once, BUSY low after it.
- LDB sign extension: ADDR=16'h3001, MEM_RDATA=16'h80_12 -> MDR=16'hFF80. Same data with ADDR=16'h3000 -> MDR=16'h0012.
- STB high lane: ADDR=16'h4001, WDATA=16'h12AB -> MEM_WE=2'b10, MEM_WDATA=16'hABAB, MEM_ADDR=16'h4000, DONE pulses.
- Unaligned STW: ADDR=16'h4001, SIZE=1 -> MEM_EN never asserted, ALIGN_ERR pulses one cycle, MDR unchanged.
- Timeout: MEM_R held 0 -> TIMEOUT_ERR after 15 ACCESS cycles, no DONE. Repeat with MEM_R=1 on the 15th cycle -> DONE, no TIMEOUT_ERR.
- Reset mid-ACCESS: assert RESET during the 2nd wait cycle -> MEM_EN, BUSY and MDR go to 0 without waiting for CLK. A new LDW after reset completes normally.
